// File: rtl/match_overlay.sv
// Draws a template-sized rectangle border over a raster pixel stream at the detector's last latched position.
// One-cycle registered latency from each ena=1 pixel; no backpressure, ena=0 cycles simply hold all state.
module match_overlay #(
    parameter int         WIDTH  = 640,
    parameter int         HEIGHT = 480,
    parameter int         BOX_W  = 40,
    parameter int         BOX_H  = 100,
    parameter logic [7:0] COLOR  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       sof,
    input  logic [7:0] pix_in,
    input  logic [9:0] xpos,
    input  logic [9:0] ypos,
    input  logic       det_valid,
    output logic [7:0] pix_out,
    output logic       out_valid,
    output logic [9:0] xout,
    output logic [9:0] yout,
    output logic       frame_done
);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [9:0]  X_LAST = 10'(WIDTH - 1);
    localparam logic [9:0]  Y_LAST = 10'(HEIGHT - 1);
    localparam logic [10:0] BW_M1  = 11'(BOX_W - 1);
    localparam logic [10:0] BH_M1  = 11'(BOX_H - 1);

    state_t      state, state_nxt;
    logic [9:0]  x, y;
    logic [9:0]  bx, by;
    logic        bon;

    logic        proc;
    logic        origin;
    logic [9:0]  px, py;
    logic [9:0]  x_nxt, y_nxt;
    logic [9:0]  cbx, cby;
    logic        cbon;
    logic [10:0] bx0, bx1, by0, by1, px11, py11;
    logic        in_x, in_y, border, last;

    // Position of the pixel being processed; sof always forces (0,0) and re-arms the box latch.
    always_comb begin
        state_nxt = state;
        proc      = 1'b0;
        origin    = 1'b0;
        px        = x;
        py        = y;
        if (ena) begin
            if (state == SYNC) begin
                if (sof) begin
                    proc      = 1'b1;
                    origin    = 1'b1;
                    px        = '0;
                    py        = '0;
                    state_nxt = RUN;
                end
            end else begin
                proc = 1'b1;
                if (sof || (x == '0 && y == '0)) begin
                    origin = 1'b1;
                    px     = '0;
                    py     = '0;
                end
            end
        end
    end

    // Origin pixel uses the freshly sampled detection, so the box applies from (0,0) onward.
    always_comb begin
        cbx  = origin ? xpos : bx;
        cby  = origin ? ypos : by;
        cbon = origin ? det_valid : bon;
        bx0  = {1'b0, cbx};
        by0  = {1'b0, cby};
        bx1  = bx0 + BW_M1;
        by1  = by0 + BH_M1;
        px11 = {1'b0, px};
        py11 = {1'b0, py};
        in_x = (px11 >= bx0) && (px11 <= bx1);
        in_y = (py11 >= by0) && (py11 <= by1);
        // Edges past the raster are never hit because px/py stay inside the frame.
        border = cbon && ((((px11 == bx0) || (px11 == bx1)) && in_y) ||
                          (((py11 == by0) || (py11 == by1)) && in_x));
        last = (px == X_LAST) && (py == Y_LAST);
    end

    always_comb begin
        x_nxt = px + 10'd1;
        y_nxt = py;
        if (px == X_LAST) begin
            x_nxt = '0;
            y_nxt = (py == Y_LAST) ? 10'd0 : py + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x          <= '0;
            y          <= '0;
            bx         <= '0;
            by         <= '0;
            bon        <= 1'b0;
            pix_out    <= '0;
            out_valid  <= 1'b0;
            xout       <= '0;
            yout       <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid <= proc;
            if (proc) begin
                pix_out    <= border ? COLOR : pix_in;
                xout       <= px;
                yout       <= py;
                frame_done <= last;
                x          <= x_nxt;
                y          <= y_nxt;
                if (origin) begin
                    bx  <= xpos;
                    by  <= ypos;
                    bon <= det_valid;
                end
            end else begin
                frame_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_match_overlay.sv
// Randomized bench for match_overlay on a reduced raster, scored against a pixel-index reference model.
module tb_match_overlay;

    localparam int         W   = 64;
    localparam int         H   = 48;
    localparam int         BW  = 10;
    localparam int         BH  = 12;
    localparam logic [7:0] COL = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena, sof, det_valid;
    logic [7:0] pix_in;
    logic [9:0] xpos, ypos;
    logic [7:0] pix_out;
    logic       out_valid, frame_done;
    logic [9:0] xout, yout;

    always #5 clk = ~clk;

    match_overlay #(
        .WIDTH (W),
        .HEIGHT(H),
        .BOX_W (BW),
        .BOX_H (BH),
        .COLOR (COL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .sof       (sof),
        .pix_in    (pix_in),
        .xpos      (xpos),
        .ypos      (ypos),
        .det_valid (det_valid),
        .pix_out   (pix_out),
        .out_valid (out_valid),
        .xout      (xout),
        .yout      (yout),
        .frame_done(frame_done)
    );

    // Reference: raster index within the frame plus the box captured at the frame origin.
    bit m_run;
    int m_k, m_bx, m_by;
    bit m_bon;

    int n_chk  = 0;
    int n_fail = 0;
    int fd_cnt, col_cnt;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Border = inside the outer rectangle but not inside the rectangle shrunk by one pixel.
    function automatic bit on_border(input int px, input int py);
        bit outer, inner;
        outer = px >= m_bx && px <= m_bx + BW - 1 && py >= m_by && py <= m_by + BH - 1;
        inner = px >= m_bx + 1 && px <= m_bx + BW - 2 && py >= m_by + 1 && py <= m_by + BH - 2;
        return m_bon && outer && !inner;
    endfunction

    task automatic step(input bit e, input bit s);
        bit         ev;
        int         ex, ey, ep, ef;
        logic [7:0] p;
        p  = 8'($urandom_range(0, 254));
        ev = 0; ex = 0; ey = 0; ep = 0; ef = 0;
        if (e && (m_run || s)) begin
            if (s || m_k == 0) begin
                m_k   = 0;
                m_bx  = int'(xpos);
                m_by  = int'(ypos);
                m_bon = det_valid;
            end
            ex    = m_k % W;
            ey    = m_k / W;
            ev    = 1;
            ep    = on_border(ex, ey) ? int'(COL) : int'(p);
            ef    = (m_k == W * H - 1) ? 1 : 0;
            m_k   = (m_k + 1) % (W * H);
            m_run = 1;
        end
        ena    = e;
        sof    = s;
        pix_in = p;
        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), int'(ev));
        if (ev) begin
            check("pix_out", int'(pix_out), ep);
            check("xout", int'(xout), ex);
            check("yout", int'(yout), ey);
            check("frame_done", int'(frame_done), ef);
        end else begin
            check("frame_done_idle", int'(frame_done), 0);
        end
        if (out_valid && frame_done) fd_cnt++;
        if (out_valid && pix_out == COL) col_cnt++;
    endtask

    task automatic pixels(input int n, input int stall_every);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0);
            if (stall_every != 0 && (i % stall_every) == stall_every - 1)
                repeat (3) step(1'b0, 1'b0);
        end
    endtask

    task automatic frame(input int stall_every);
        step(1'b1, 1'b1);
        pixels(W * H - 1, stall_every);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_pix_out"}, int'(pix_out), 0);
        check({tag, "_xout"}, int'(xout), 0);
        check({tag, "_yout"}, int'(yout), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    initial begin
        rst = 1'b0; ena = 1'b0; sof = 1'b0; pix_in = '0;
        xpos = '0; ypos = '0; det_valid = 1'b0;
        m_run = 0; m_k = 0; m_bx = 0; m_by = 0; m_bon = 0;
        fd_cnt = 0; col_cnt = 0;
        #23;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst = 1'b1;

        // Pixels before any sof are dropped.
        repeat (10) step(1'b1, 1'b0);

        // Full frame with box fully inside the raster.
        xpos = 10'd20; ypos = 10'd10; det_valid = 1'b1;
        fd_cnt = 0; col_cnt = 0;
        frame(0);
        check("full_border_cnt", col_cnt, 2 * BW + 2 * BH - 4);
        check("full_fd_cnt", fd_cnt, 1);

        // Box clipped at bottom-right: only left column and top row segments remain.
        xpos = 10'(W - 5); ypos = 10'(H - 4);
        fd_cnt = 0; col_cnt = 0;
        frame(0);
        check("clip_border_cnt", col_cnt, 4 + 5 - 1);
        check("clip_fd_cnt", fd_cnt, 1);

        // Detection moves mid-frame; takes effect only at the next origin (natural wrap, no sof).
        xpos = 10'd20; ypos = 10'd10;
        fd_cnt = 0; col_cnt = 0;
        step(1'b1, 1'b1);
        pixels(W * (H / 2) - 1, 0);
        xpos = 10'd40;
        pixels(W * H - W * (H / 2), 0);
        check("move_cur_cnt", col_cnt, 2 * BW + 2 * BH - 4);
        col_cnt = 0;
        pixels(W * H, 0);
        check("move_next_cnt", col_cnt, 2 * BW + 2 * BH - 4);
        check("move_fd_cnt", fd_cnt, 2);

        // Stalled frame must give the same stream as unstalled.
        xpos = 10'd20; ypos = 10'd10;
        fd_cnt = 0; col_cnt = 0;
        frame(5);
        check("stall_border_cnt", col_cnt, 2 * BW + 2 * BH - 4);
        check("stall_fd_cnt", fd_cnt, 1);

        // Resync mid-frame with no detection.
        det_valid = 1'b0;
        fd_cnt = 0; col_cnt = 0;
        step(1'b1, 1'b1);
        pixels(2 * W + W / 2 - 1, 0);
        step(1'b1, 1'b1);
        check("resync_x", int'(xout), 0);
        check("resync_y", int'(yout), 0);
        check("trunc_fd_cnt", fd_cnt, 0);
        pixels(W * H - 1, 0);
        check("nodet_border_cnt", col_cnt, 0);
        check("nodet_fd_cnt", fd_cnt, 1);

        // Reset mid-frame discards the frame; nothing out until the next sof.
        det_valid = 1'b1; xpos = 10'd3; ypos = 10'd2;
        step(1'b1, 1'b1);
        pixels(100, 0);
        ena = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("arst");
        m_run = 0; m_k = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        pixels(200, 0);

        // Random stress: ena gaps, rare sof, detector levels wandering every cycle.
        for (int i = 0; i < 6000; i++) begin
            xpos      = 10'($urandom_range(0, W + 5));
            ypos      = 10'($urandom_range(0, H + 5));
            det_valid = 1'($urandom_range(0, 3) != 0);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 999) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
